bitcoin_nonce_search: RTL and testbench
=======================================

BITCOIN_NONCE_SEARCH -- requirements
Module: bitcoin_nonce_search

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 19: header words read from memory, excluding the nonce; legal range 16..27.
REQ-002 SHALL have parameter NUM_NONCES, default 16: nonces tested per run; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = ALL (write the digest word for every nonce); 1 = MATCH (stop at the first nonce that meets target).
REQ-007 SHALL have port nonce_start, input, 32 bits: first nonce value; captured at start.
REQ-008 SHALL have port target, input, 32 bits: MATCH threshold; captured at start.
REQ-009 SHALL have ports message_addr and output_addr, input, 16 bits each: word base addresses; captured at start.
REQ-010 SHALL have port done, output, 1 bit: high exactly when state == IDLE.
REQ-011 SHALL have port found, output, 1 bit: MATCH succeeded in the last run.
REQ-012 SHALL have port found_nonce, output, 32 bits: the nonce that matched.
REQ-013 SHALL have port mem_clk, output, 1 bit: equals clk.
REQ-014 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-015 SHALL have port mem_addr, output, 16 bits: memory word address.
REQ-016 SHALL have port mem_write_data, output, 32 bits: memory write data.
REQ-017 SHALL have port mem_read_data, input, 32 bits: read data, valid one cycle after the address is presented.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, MID, BLK2, PASS2, CHECK, WRITE, with one SHA-256 round per COMPUTE cycle.
REQ-019 In IDLE, start = 1 SHALL capture all inputs, clear found, and enter READ; start is ignored outside IDLE.
REQ-020 READ SHALL issue addresses message_addr+0 .. message_addr+NUM_WORDS-1 on consecutive cycles with mem_we = 0, and store each word one cycle later: NUM_WORDS+1 cycles total.
REQ-021 MID SHALL compress header block 0 (words 0..15) once per run from the SHA-256 IV and store the midstate; it SHALL NOT be recomputed per nonce.
REQ-022 BLK2 SHALL compress block 1 from the midstate, with w = remaining header words, then the nonce, then 0x80000000, then zero fill, then a 64-bit length of (NUM_WORDS+1)*32 in w[14:15].
REQ-023 PASS2 SHALL compute SHA-256 of the 256-bit digest from BLK2 (single block, padding 0x80000000 at w[8], length 256) starting from the IV; H0 of the result is the nonce score.
REQ-024 Message schedule: w[t] for t >= 16 SHALL be computed on the fly in a 16-entry circular buffer; all additions are modulo 2^32.
REQ-025 Compress latency SHALL be 64 round cycles plus 1 cycle for the final add, giving a per-nonce cost of 130 cycles (BLK2 + PASS2) plus 1 CHECK cycle.
REQ-026 In ALL mode, CHECK SHALL write the score to output_addr + n (n = nonce index 0..NUM_NONCES-1) with mem_we pulsed for 1 cycle.
REQ-027 In MATCH mode, a score strictly below target SHALL set found = 1 and found_nonce = current nonce, write the score to output_addr, then return to IDLE without testing further nonces.
REQ-028 Nonce arithmetic SHALL wrap from 0xFFFFFFFF to 0x00000000 without error; the run ends after NUM_NONCES nonces, or at the first match in MATCH mode.
REQ-029 A MATCH run that finds no match SHALL leave found = 0, issue no writes, and return to IDLE.
REQ-030 mem_we SHALL be 0 in every state except the CHECK write cycle.
REQ-031 found and found_nonce SHALL hold their values until the next start.

Reset
REQ-032 When reset_n = 0 at a clk edge, the block SHALL enter IDLE with done=1, found=0, found_nonce=0, mem_we=0, mem_addr=0, mem_write_data=0, and the nonce index cleared.
REQ-033 Reset asserted mid-run, in any state, SHALL abort immediately with no further memory writes; the next start SHALL run from scratch.

Verification
REQ-034 Reset: hold reset_n=0 for 2 cycles, then release -> done=1, found=0, mem_we=0, and no writes while start=0.
REQ-035 ALL mode with defaults, nonce_start=0, random header -> exactly 16 writes to output_addr+0..15, each equal to H0 of the double-SHA-256 software model; done rises 20 + 65 + 16*131 cycles after start (±1).
REQ-036 MATCH mode with target=0xFFFFFFFF -> found=1, found_nonce=nonce_start, exactly one write at output_addr.
REQ-037 MATCH mode with target=0 -> found=0, no writes, done after all 16 nonces.
REQ-038 Wrap: nonce_start=0xFFFFFFFE, NUM_NONCES=4 -> scores match the model for nonces FFFFFFFE, FFFFFFFF, 0, 1.
REQ-039 Reset asserted during PASS2 of nonce 3, then start again -> the aborted run makes no further writes, and the new run's outputs match the model.

Source files
------------

// File: rtl/bitcoin_nonce_search.sv
// Bitcoin-style nonce search: reads a block header from word memory, compresses
// the first 64 bytes once (midstate), then for each nonce runs the second header
// block and a second SHA-256 pass, scoring the nonce by H0 of the double hash.
// One SHA-256 round per cycle on a single shared round engine.
module bitcoin_nonce_search #(
    parameter int NUM_WORDS  = 19,
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] nonce_start,
    input  logic [31:0] target,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // IDLE -> READ -> MID -> { BLK2 -> PASS2 -> CHECK }* -> WRITE -> IDLE
    // WRITE is the single end-of-run cycle that publishes found/found_nonce.
    typedef enum logic [2:0] {IDLE, READ, MID, BLK2, PASS2, CHECK, WRITE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [6:0]  LAST_ROUND = 7'd64;
    localparam logic [6:0]  READ_LAST  = 7'(NUM_WORDS);
    localparam logic [15:0] LAST_IDX   = 16'(NUM_NONCES - 1);
    // Word positions inside the second header block
    localparam logic [3:0]  NONCE_POS  = 4'(NUM_WORDS - 16);
    localparam logic [3:0]  PAD_POS    = 4'(NUM_WORDS - 15);
    localparam logic [31:0] BLK2_LEN   = 32'((NUM_WORDS + 1) * 32);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  rnd_q, rnd_d;             // round counter, also the READ cycle counter
    logic [15:0] idx_q, idx_d;             // nonce index within the run
    logic [31:0] nonce_q, nonce_d;
    logic [31:0] target_q, target_d;
    logic [15:0] msg_base_q, msg_base_d;
    logic [15:0] out_base_q, out_base_d;
    logic        mode_q, mode_d;
    logic        match_q, match_d;
    logic        found_q, found_d;
    logic [31:0] found_nonce_q, found_nonce_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] hdr_q  [32];
    logic [31:0] hdr_d  [32];
    logic [31:0] wbuf_q [16];
    logic [31:0] wbuf_d [16];
    logic [31:0] wk_q   [8];
    logic [31:0] wk_d   [8];
    logic [31:0] mid_q  [8];
    logic [31:0] mid_d  [8];
    logic [31:0] dig_q  [8];
    logic [31:0] dig_d  [8];

    logic [3:0]  t_idx;
    logic [31:0] msg_word, wt, t1, t2, score;
    logic [31:0] rnd_wk [8];
    logic        last_nonce;

    assign done           = (state_q == IDLE);
    assign found          = found_q;
    assign found_nonce    = found_nonce_q;
    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign last_nonce     = (idx_q == LAST_IDX) || match_q;
    assign score          = IV[0] + wk_q[0];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (rnd_q == READ_LAST) state_d = MID;
            MID:     if (rnd_q == LAST_ROUND) state_d = BLK2;
            BLK2:    if (rnd_q == LAST_ROUND) state_d = PASS2;
            PASS2:   if (rnd_q == LAST_ROUND) state_d = CHECK;
            CHECK:   state_d = last_nonce ? WRITE : BLK2;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round engine: block word source, on-the-fly schedule and one SHA-256 round
    always_comb begin
        t_idx    = rnd_q[3:0];
        msg_word = 32'h0;
        case (state_q)
            MID:   msg_word = hdr_q[{1'b0, t_idx}];
            BLK2: begin
                if (t_idx < NONCE_POS)       msg_word = hdr_q[{1'b1, t_idx}];
                else if (t_idx == NONCE_POS) msg_word = nonce_q;
                else if (t_idx == PAD_POS)   msg_word = 32'h8000_0000;
                else if (t_idx == 4'd15)     msg_word = BLK2_LEN;
                else                         msg_word = 32'h0;
            end
            PASS2: begin
                if (t_idx < 4'd8)        msg_word = dig_q[t_idx[2:0]];
                else if (t_idx == 4'd8)  msg_word = 32'h8000_0000;
                else if (t_idx == 4'd15) msg_word = 32'd256;
                else                     msg_word = 32'h0;
            end
            default: msg_word = 32'h0;
        endcase
        // wbuf[t mod 16] still holds w[t-16] when round t begins
        if (rnd_q[6:4] == 3'd0) wt = msg_word;
        else wt = ssig1(wbuf_q[t_idx - 4'd2]) + wbuf_q[t_idx - 4'd7]
                + ssig0(wbuf_q[t_idx - 4'd15]) + wbuf_q[t_idx];
        t1 = wk_q[7] + bsig1(wk_q[4]) + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
           + K[rnd_q[5:0]] + wt;
        t2 = bsig0(wk_q[0]) + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
        rnd_wk[0] = t1 + t2;
        rnd_wk[1] = wk_q[0];
        rnd_wk[2] = wk_q[1];
        rnd_wk[3] = wk_q[2];
        rnd_wk[4] = wk_q[3] + t1;
        rnd_wk[5] = wk_q[4];
        rnd_wk[6] = wk_q[5];
        rnd_wk[7] = wk_q[6];
    end

    // Datapath and output register updates for each state
    always_comb begin
        rnd_d         = rnd_q;
        idx_d         = idx_q;
        nonce_d       = nonce_q;
        target_d      = target_q;
        msg_base_d    = msg_base_q;
        out_base_d    = out_base_q;
        mode_d        = mode_q;
        match_d       = match_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = 16'h0;
        mem_wdata_d   = 32'h0;
        hdr_d         = hdr_q;
        wbuf_d        = wbuf_q;
        wk_d          = wk_q;
        mid_d         = mid_q;
        dig_d         = dig_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d        = mode;
                    nonce_d       = nonce_start;
                    target_d      = target;
                    msg_base_d    = message_addr;
                    out_base_d    = output_addr;
                    rnd_d         = 7'd0;
                    idx_d         = 16'd0;
                    match_d       = 1'b0;
                    found_d       = 1'b0;
                    found_nonce_d = 32'h0;
                    mem_addr_d    = message_addr;  // first read address visible in READ cycle 0
                end
            end
            READ: begin
                // Word presented in cycle c arrives in cycle c+1
                if (rnd_q != 7'd0) hdr_d[rnd_q[4:0] - 5'd1] = mem_read_data;
                if (rnd_q < READ_LAST - 7'd1) mem_addr_d = msg_base_q + 16'(rnd_q) + 16'd1;
                rnd_d = rnd_q + 7'd1;
                if (rnd_q == READ_LAST) begin
                    rnd_d = 7'd0;
                    wk_d  = IV;
                end
            end
            MID, BLK2, PASS2: begin
                if (rnd_q != LAST_ROUND) begin
                    wk_d           = rnd_wk;
                    wbuf_d[t_idx]  = wt;
                    rnd_d          = rnd_q + 7'd1;
                end else begin
                    rnd_d = 7'd0;
                    if (state_q == MID) begin
                        for (int i = 0; i < 8; i++) mid_d[i] = IV[i] + wk_q[i];
                        wk_d = mid_d;
                    end else if (state_q == BLK2) begin
                        for (int i = 0; i < 8; i++) dig_d[i] = mid_q[i] + wk_q[i];
                        wk_d = IV;
                    end else begin
                        // Score is ready: stage the write so it lands during CHECK
                        mem_wdata_d = score;
                        if (!mode_q) begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = out_base_q + idx_q;
                        end else if (score < target_q) begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = out_base_q;
                            match_d    = 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                if (!last_nonce) begin
                    idx_d   = idx_q + 16'd1;
                    nonce_d = nonce_q + 32'd1;
                    wk_d    = mid_q;
                end
            end
            WRITE: begin
                if (match_q) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                end
            end
            default: ;
        endcase
    end

    // Control and memory-port registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rnd_q         <= 7'd0;
            idx_q         <= 16'd0;
            nonce_q       <= 32'h0;
            target_q      <= 32'h0;
            msg_base_q    <= 16'h0;
            out_base_q    <= 16'h0;
            mode_q        <= 1'b0;
            match_q       <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= 32'h0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 16'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            rnd_q         <= rnd_d;
            idx_q         <= idx_d;
            nonce_q       <= nonce_d;
            target_q      <= target_d;
            msg_base_q    <= msg_base_d;
            out_base_q    <= out_base_d;
            mode_q        <= mode_d;
            match_q       <= match_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Hash working storage; always rewritten before use within a run
    always_ff @(posedge clk) begin
        hdr_q  <= hdr_d;
        wbuf_q <= wbuf_d;
        wk_q   <= wk_d;
        mid_q  <= mid_d;
        dig_q  <= dig_d;
    end

endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// Bench for bitcoin_nonce_search: random headers in a word memory, results
// compared with a message-level double SHA-256 reference.
module tb_bitcoin_nonce_search;
  localparam int NW       = 19;
  localparam int MSG_BASE = 32;
  localparam int OUT_BASE = 128;

  typedef logic [0:7][31:0] w8_t;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam w8_t IVT = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [15:0] msg_addr, out_addr;
  logic        start1, mode1, start2, mode2;
  logic [31:0] nonce1, target1, nonce2, target2;
  logic        done1, found1, mclk1, we1, done2, found2, mclk2, we2;
  logic [31:0] fnonce1, wdata1, rdata1, fnonce2, wdata2, rdata2;
  logic [15:0] addr1, addr2;

  bitcoin_nonce_search dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode1),
    .nonce_start(nonce1), .target(target1), .message_addr(msg_addr), .output_addr(out_addr),
    .done(done1), .found(found1), .found_nonce(fnonce1), .mem_clk(mclk1),
    .mem_we(we1), .mem_addr(addr1), .mem_write_data(wdata1), .mem_read_data(rdata1)
  );

  bitcoin_nonce_search #(.NUM_WORDS(19), .NUM_NONCES(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode2),
    .nonce_start(nonce2), .target(target2), .message_addr(msg_addr), .output_addr(out_addr),
    .done(done2), .found(found2), .found_nonce(fnonce2), .mem_clk(mclk2),
    .mem_we(we2), .mem_addr(addr2), .mem_write_data(wdata2), .mem_read_data(rdata2)
  );

  // Word memory: registered read, writes captured into per-DUT logs
  logic [31:0] rmem [0:255];
  logic [15:0] wa1[$], wa2[$];
  logic [31:0] wd1[$], wd2[$];

  always @(posedge clk) begin
    rdata1 <= rmem[addr1[7:0]];
    rdata2 <= rmem[addr2[7:0]];
  end

  always @(negedge clk) begin
    if (we1 === 1'b1) begin wa1.push_back(addr1); wd1.push_back(wdata1); end
    if (we2 === 1'b1) begin wa2.push_back(addr2); wd2.push_back(wdata2); end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // SHA-256 of a whole-word message of n words (padding done here)
  function automatic w8_t sha256_words(input logic [31:0] m [0:63], input int n);
    logic [31:0] p [0:63];
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] s0, s1, x1, x2;
    w8_t h;
    int total;
    for (int i = 0; i < 64; i++) p[i] = (i < n) ? m[i] : 32'h0;
    p[n] = 32'h8000_0000;
    total = ((n + 3 + 15) / 16) * 16;
    p[total - 1] = 32'(n * 32);
    h = IVT;
    for (int b = 0; b < total / 16; b++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = p[b * 16 + t];
        else begin
          s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
          s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
          w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
      end
      for (int i = 0; i < 8; i++) v[i] = h[i];
      for (int t = 0; t < 64; t++) begin
        x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
        x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int i = 7; i > 0; i--) v[i] = v[i-1];
        v[4] = v[4] + x1;
        v[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
    end
    return h;
  endfunction

  function automatic logic [31:0] model_score(input logic [31:0] nonce);
    logic [31:0] m [0:63];
    w8_t d1, d2;
    for (int i = 0; i < 64; i++) m[i] = 32'h0;
    for (int i = 0; i < NW; i++) m[i] = rmem[MSG_BASE + i];
    m[NW] = nonce;
    d1 = sha256_words(m, NW + 1);
    for (int i = 0; i < 64; i++) m[i] = 32'h0;
    for (int i = 0; i < 8; i++) m[i] = d1[i];
    d2 = sha256_words(m, 8);
    return d2[0];
  endfunction

  // ---------------- scoreboard ----------------
  int total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic go(input int which, input logic m, input logic [31:0] ns, input logic [31:0] tg);
    if (which == 1) begin wa1.delete(); wd1.delete(); end
    else begin wa2.delete(); wd2.delete(); end
    @(negedge clk);
    if (which == 1) begin mode1 = m; nonce1 = ns; target1 = tg; start1 = 1'b1; end
    else begin mode2 = m; nonce2 = ns; target2 = tg; start2 = 1'b1; end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int max, output int cyc);
    cyc = 0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("done_within_budget_dut%0d", which), 32'(cyc < max), 32'd1);
  endtask

  task automatic check_writes(input int which, input string tag, input logic [31:0] ns, input int n_exp);
    logic [31:0] exp_q[$];
    int n_obs;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(model_score(ns + 32'(i)));
    n_obs = (which == 1) ? wa1.size() : wa2.size();
    chk({tag, "_nwrites"}, 32'(n_obs), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n_obs; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {16'h0, (which == 1) ? wa1[i] : wa2[i]}, 32'(OUT_BASE + i));
      chk($sformatf("%s_score%0d", tag, i), (which == 1) ? wd1[i] : wd2[i], exp_q.pop_front());
    end
  endtask

  task automatic match_run(input string tag, input logic [31:0] ns, input logic [31:0] tg);
    logic        e_found;
    logic [31:0] e_nonce, e_score, s;
    int cyc;
    e_found = 1'b0; e_nonce = 32'h0; e_score = 32'h0;
    for (int i = 0; i < 16; i++) begin
      s = model_score(ns + 32'(i));
      if (!e_found && s < tg) begin e_found = 1'b1; e_nonce = ns + 32'(i); e_score = s; end
    end
    go(1, 1'b1, ns, tg);
    wait_done(1, 3000, cyc);
    chk({tag, "_found"}, {31'h0, found1}, {31'h0, e_found});
    chk({tag, "_nwrites"}, 32'(wa1.size()), e_found ? 32'd1 : 32'd0);
    if (e_found) begin
      chk({tag, "_found_nonce"}, fnonce1, e_nonce);
      if (wa1.size() > 0) begin
        chk({tag, "_waddr"}, {16'h0, wa1[0]}, 32'(OUT_BASE));
        chk({tag, "_wdata"}, wd1[0], e_score);
      end
    end else begin
      chk({tag, "_cycles"}, 32'(cyc >= 2180 && cyc <= 2182), 32'd1);
    end
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_found_hold"}, {31'h0, found1}, {31'h0, e_found});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] m [0:63];
    w8_t d;
    logic [31:0] ns;
    int cyc, nw;
    total = 0; bad = 0;
    reset_n = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; nonce1 = 32'h0; target1 = 32'h0;
    start2 = 1'b0; mode2 = 1'b0; nonce2 = 32'h0; target2 = 32'h0;
    msg_addr = 16'(MSG_BASE);
    out_addr = 16'(OUT_BASE);
    for (int i = 0; i < 256; i++) rmem[i] = $urandom;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_done", {31'h0, done1}, 32'd1);
    chk("rst_found", {31'h0, found1}, 32'd0);
    chk("rst_found_nonce", fnonce1, 32'h0);
    chk("rst_mem_we", {31'h0, we1}, 32'd0);
    chk("rst_mem_addr", {16'h0, addr1}, 32'h0);
    chk("rst_mem_wdata", wdata1, 32'h0);
    chk("rst_done_w", {31'h0, done2}, 32'd1);
    repeat (10) @(negedge clk);
    chk("idle_no_writes", 32'(wa1.size() + wa2.size()), 32'd0);
    chk("idle_done", {31'h0, done1}, 32'd1);

    // Reference sanity: SHA-256 of the empty message
    for (int i = 0; i < 64; i++) m[i] = 32'h0;
    d = sha256_words(m, 0);
    chk("model_empty_h0", d[0], 32'he3b0c442);

    // ALL mode, nonce_start = 0, latency check
    go(1, 1'b0, 32'h0, $urandom);
    wait_done(1, 3000, cyc);
    total++;
    assert (cyc >= 2180 && cyc <= 2182) else begin
      bad++;
      $error("FAIL all_latency: observed=%0d expected=2181", cyc);
    end
    check_writes(1, "all0", 32'h0, 16);
    chk("all0_found", {31'h0, found1}, 32'd0);

    // MATCH mode variants
    match_run("match_max", $urandom, 32'hFFFF_FFFF);
    match_run("match_zero", $urandom, 32'h0);
    match_run("match_rand", $urandom, $urandom_range(0, 32'h3FFF_FFFF));

    // New header, then nonce wrap on the 4-nonce instance
    for (int i = 0; i < NW; i++) rmem[MSG_BASE + i] = $urandom;
    go(2, 1'b0, 32'hFFFF_FFFE, 32'h0);
    wait_done(2, 1000, cyc);
    check_writes(2, "wrap", 32'hFFFF_FFFE, 4);

    // Reset during PASS2 of nonce index 3
    go(1, 1'b0, $urandom, 32'h0);
    cyc = 0;
    while (wa1.size() < 3 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("abort_reached_nonce3", 32'(cyc < 1000), 32'd1);
    repeat (65 + 30) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nw = wa1.size();
    chk("abort_writes_before", 32'(nw), 32'd3);
    chk("abort_done", {31'h0, done1}, 32'd1);
    chk("abort_mem_we", {31'h0, we1}, 32'd0);
    repeat (300) @(negedge clk);
    chk("abort_no_more_writes", 32'(wa1.size()), 32'(nw));

    // Fresh run after the abort
    ns = $urandom;
    go(1, 1'b0, ns, 32'h0);
    wait_done(1, 3000, cyc);
    check_writes(1, "rerun", ns, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
